// File: rtl/pulpino_clkrst_gen.sv
// Clock/reset generator: divides the board clock into usr_clk, sequences the
// SoC reset release onto a usr_clk falling edge and debounces the fetch-enable switch.
module pulpino_clkrst_gen #(
  parameter int DIV_HALF   = 5,
  parameter int RST_HOLD   = 32,
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_rst_req_i,
  input  logic fetch_enable_i,
  output logic usr_clk,
  output logic usr_rst_n,
  output logic fetch_enable_o,
  output logic sys_ready_o
);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [3:0]  DIV_LAST  = 4'(DIV_HALF - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD - 1);
  localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 1);

  logic [3:0]  div_cnt_q, div_cnt_d;
  logic        usr_clk_q, usr_clk_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        usr_rst_n_q, usr_rst_n_d;
  logic        sys_ready_q, sys_ready_d;
  logic        sync1_q, sync2_q;
  logic        fe_stable_q, fe_stable_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic        fe_o_q, fe_o_d;

  logic div_wrap;
  logic usr_clk_fall;

  assign div_wrap     = (div_cnt_q == DIV_LAST);
  assign usr_clk_fall = div_wrap & usr_clk_q;

  always_comb begin
    div_cnt_d = div_wrap ? 4'd0 : div_cnt_q + 4'd1;
    usr_clk_d = div_wrap ? ~usr_clk_q : usr_clk_q;
  end

  // Soft reset overrides every transition, including a pending release.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    usr_rst_n_d = usr_rst_n_q;
    sys_ready_d = sys_ready_q;
    if (sw_rst_req_i) begin
      state_d     = ST_HOLD;
      hold_cnt_d  = 8'd0;
      usr_rst_n_d = 1'b0;
      sys_ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          usr_rst_n_d = 1'b0;
          sys_ready_d = 1'b0;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_RELEASE;
            hold_cnt_d = 8'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
        ST_RELEASE: begin
          if (usr_clk_fall) begin
            state_d     = ST_RUN;
            usr_rst_n_d = 1'b1;
            sys_ready_d = 1'b1;
          end
        end
        ST_RUN: begin
          usr_rst_n_d = 1'b1;
          sys_ready_d = 1'b1;
        end
        default: begin
          state_d     = ST_HOLD;
          hold_cnt_d  = 8'd0;
          usr_rst_n_d = 1'b0;
          sys_ready_d = 1'b0;
        end
      endcase
    end
  end

  // The counter parks at its terminal value rather than wrapping.
  always_comb begin
    fe_stable_d = fe_stable_q;
    deb_cnt_d   = 16'd0;
    if (sync2_q != fe_stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        fe_stable_d = sync2_q;
        deb_cnt_d   = deb_cnt_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 16'd1;
      end
    end
    fe_o_d = fe_stable_q & (state_q == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= 4'd0;
      usr_clk_q   <= 1'b0;
      state_q     <= ST_HOLD;
      hold_cnt_q  <= 8'd0;
      usr_rst_n_q <= 1'b0;
      sys_ready_q <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      fe_stable_q <= 1'b0;
      deb_cnt_q   <= 16'd0;
      fe_o_q      <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      usr_clk_q   <= usr_clk_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      usr_rst_n_q <= usr_rst_n_d;
      sys_ready_q <= sys_ready_d;
      sync1_q     <= fetch_enable_i;
      sync2_q     <= sync1_q;
      fe_stable_q <= fe_stable_d;
      deb_cnt_q   <= deb_cnt_d;
      fe_o_q      <= fe_o_d;
    end
  end

  assign usr_clk        = usr_clk_q;
  assign usr_rst_n      = usr_rst_n_q;
  assign sys_ready_o    = sys_ready_q;
  assign fetch_enable_o = fe_o_q;

endmodule

// File: tb/tb_pulpino_clkrst_gen.sv
// Directed bench for pulpino_clkrst_gen: boot sequence, debounce, soft reset
// in RUN and RELEASE, and an asynchronous reset pulse mid-RUN.
module tb_pulpino_clkrst_gen;

  localparam int DIV_HALF = 5;
  localparam int RST_HOLD = 32;
  localparam int DEB      = 8;
  localparam int UPER     = 2 * DIV_HALF;

  logic clk = 1'b0;
  logic rst_n, sw, fe;
  logic usr_clk, usr_rst_n, fe_o, rdy;

  int n_chk  = 0;
  int n_pass = 0;
  int ecnt   = 0;
  bit track  = 1'b0;

  pulpino_clkrst_gen #(
    .DIV_HALF  (DIV_HALF),
    .RST_HOLD  (RST_HOLD),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_rst_req_i  (sw),
    .fetch_enable_i(fe),
    .usr_clk       (usr_clk),
    .usr_rst_n     (usr_rst_n),
    .fetch_enable_o(fe_o),
    .sys_ready_o   (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (track) chk("usr_clk_phase", usr_clk, 32'((ecnt / DIV_HALF) % 2));
  endtask

  // First usr_clk falling edge once the hold window started after edge l has expired.
  function automatic int first_run(input int l);
    int e;
    e = l + RST_HOLD + 1;
    while ((e % UPER) != 0) e++;
    return e;
  endfunction

  task automatic wait_run(input int l);
    int r;
    r = first_run(l);
    while (ecnt < r + 1) begin
      tick();
      chk("usr_rst_n_seq", usr_rst_n, 32'(ecnt >= r));
      chk("sys_ready_seq", rdy, 32'(ecnt >= r));
      chk("fe_o_seq", fe_o, 32'(ecnt >= r + 1));
    end
  endtask

  task automatic boot_seq();
    wait_run(0);
    repeat (4) begin
      tick();
      chk("boot_run_hold", usr_rst_n, 32'd1);
      chk("boot_fe_hold", fe_o, 32'd1);
    end
  endtask

  initial begin
    int k, j, l1, l2;
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k, j, l1, l2;
    rst_n = 1'b1; sw = 1'b0; fe = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_usr_clk", usr_clk, 32'd0);
    chk("rst_usr_rst_n", usr_rst_n, 32'd0);
    chk("rst_fe_o", fe_o, 32'd0);
    chk("rst_sys_ready", rdy, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_usr_clk", usr_clk, 32'd0);
    chk("rst_hold_usr_rst_n", usr_rst_n, 32'd0);
    rst_n = 1'b1;
    ecnt  = 0;
    track = 1'b1;
    boot_seq();

    // fetch switch off: synchroniser + debounce latency, then one more for the output flop
    k = ecnt;
    fe = 1'b0;
    while (ecnt < k + 11) begin
      tick();
      chk("fe_drop", fe_o, 32'(ecnt < k + 11));
    end
    repeat (3) tick();

    // 7-cycle glitch must be rejected
    fe = 1'b1;
    repeat (7) begin tick(); chk("glitch_fe_o", fe_o, 32'd0); end
    fe = 1'b0;
    repeat (20) begin tick(); chk("glitch_fe_o", fe_o, 32'd0); end

    // 10-cycle pulse is accepted, then its falling edge is debounced too
    j = ecnt;
    fe = 1'b1;
    repeat (10) begin tick(); chk("pulse_rise", fe_o, 32'd0); end
    fe = 1'b0;
    while (ecnt < j + 21) begin
      tick();
      chk("pulse_fe_o", fe_o, 32'((ecnt >= j + 11) && (ecnt < j + 21)));
    end
    fe = 1'b1;
    repeat (15) tick();
    chk("fe_back_on", fe_o, 32'd1);

    // soft reset pulse in RUN
    sw = 1'b1;
    tick();
    l1 = ecnt;
    sw = 1'b0;
    chk("sw_usr_rst_n", usr_rst_n, 32'd0);
    chk("sw_sys_ready", rdy, 32'd0);
    chk("sw_fe_o_lag", fe_o, 32'd1);
    wait_run(l1);

    // soft reset, then a 3-cycle request landing inside RELEASE
    sw = 1'b1;
    tick();
    l1 = ecnt;
    sw = 1'b0;
    while (ecnt < l1 + RST_HOLD) begin
      tick();
      chk("hold_usr_rst_n", usr_rst_n, 32'd0);
    end
    sw = 1'b1;
    repeat (3) begin
      tick();
      chk("abort_usr_rst_n", usr_rst_n, 32'd0);
      chk("abort_sys_ready", rdy, 32'd0);
    end
    l2 = ecnt;
    sw = 1'b0;
    wait_run(l2);

    // async reset glitch mid-RUN while usr_clk is high
    for (int i = 0; i < UPER && ((ecnt / DIV_HALF) % 2) == 0; i++) tick();
    chk("pre_glitch_usr_clk", usr_clk, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("glitch_usr_rst_n", usr_rst_n, 32'd0);
    chk("glitch_usr_clk", usr_clk, 32'd0);
    chk("glitch_fe_o", fe_o, 32'd0);
    chk("glitch_sys_ready", rdy, 32'd0);
    #1 rst_n = 1'b1;
    ecnt = 0;
    boot_seq();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pulpino_clkrst_gen.md
PULPINO_CLKRST_GEN -- requirements
Module: pulpino_clkrst_gen

Interface
REQ-001 SHALL have parameter DIV_HALF, default 5, clk edges per usr_clk half-period (legal range 1..15; 50 MHz in gives 5 MHz out).
REQ-002 SHALL have parameter RST_HOLD, default 32, clk cycles usr_rst_n is held low after any reset cause (legal range 2..255).
REQ-003 SHALL have parameter DEB_CYCLES, default 50000, clk cycles fetch input must be stable before acceptance (legal range 2..65535).
REQ-004 clk  input  1  board clock; the only clock of the block.
REQ-005 rst_n  input  1  asynchronous active-low reset for every flop.
REQ-006 sw_rst_req_i  input  1  synchronous soft-reset request pulse (watchdog/debug), active high.
REQ-007 fetch_enable_i  input  1  raw asynchronous fetch-enable switch, active high.
REQ-008 usr_clk  output  1  divided SoC clock, driven directly from a flop.
REQ-009 usr_rst_n  output  1  SoC reset, active low.
REQ-010 fetch_enable_o  output  1  debounced, sequenced fetch enable for the core.
REQ-011 sys_ready_o  output  1  high while the sequencer is in RUN.

Function
REQ-012 Divider: div_cnt counts 0..DIV_HALF-1 and wraps; usr_clk toggles on the clk edge where div_cnt==DIV_HALF-1; usr_clk period is exactly 2*DIV_HALF clk cycles, 50% duty.
REQ-013 Divider SHALL free-run in every sequencer state and SHALL NOT be affected by sw_rst_req_i.
REQ-014 Sequencer states: HOLD, RELEASE, RUN; encoding is free.
REQ-015 HOLD: usr_rst_n=0; hold_cnt increments each clk from 0; on the edge where hold_cnt==RST_HOLD-1 go to RELEASE.
REQ-016 RELEASE: usr_rst_n=0; on the clk edge where usr_clk toggles 1->0, usr_rst_n SHALL go to 1 on that same edge and state goes to RUN.
REQ-017 RUN: usr_rst_n=1, sys_ready_o=1; stay until sw_rst_req_i.
REQ-018 sw_rst_req_i high on any edge, in any state, SHALL force state to HOLD, hold_cnt to 0 and usr_rst_n to 0 on that edge; it has priority over every other transition (HOLD counting restarts, RELEASE aborts).
REQ-019 A sw_rst_req_i held high for N cycles SHALL keep the block in HOLD with hold_cnt at 0; counting resumes on the first cycle it is low.
REQ-020 fetch_enable_i SHALL pass a 2-flop synchroniser before use.
REQ-021 Debounce: fe_stable takes the synchronised value only after it has differed from fe_stable for DEB_CYCLES consecutive clk cycles; any cycle of agreement clears the debounce counter to 0.
REQ-022 Debounce counter SHALL saturate at its terminal value and SHALL NOT wrap.
REQ-023 fetch_enable_o SHALL be registered as fe_stable AND (state==RUN), so it updates one clk after either term changes.
REQ-024 sw_rst_req_i SHALL drop fetch_enable_o one clk after the request edge; debounce state is preserved across a soft reset.

Reset
REQ-025 On rst_n low, asynchronously: div_cnt=0, usr_clk=0, state=HOLD, hold_cnt=0, usr_rst_n=0, synchroniser flops=0, fe_stable=0, debounce counter=0, fetch_enable_o=0, sys_ready_o=0.
REQ-026 usr_rst_n SHALL assert low immediately, with no clock needed, when rst_n falls, including mid-RUN.
REQ-027 After rst_n rises, first usr_clk rising edge SHALL occur on clk edge DIV_HALF (counting edges from 1).

Verification
REQ-028 Defaults, release rst_n -> usr_clk period 10 clk; usr_rst_n rises on first usr_clk falling edge at or after edge 32; sys_ready_o=1 on that same edge.
REQ-029 DEB_CYCLES=8, fetch_enable_i high throughout, reach RUN -> fetch_enable_o=1 exactly 1 clk after RUN entry, and not before RUN.
REQ-030 DEB_CYCLES=8, fetch_enable_i glitch 1 for 7 cycles then 0 -> fetch_enable_o stays 0; a 10-cycle high pulse -> fe_stable set after 8 cycles of disagreement, plus synchroniser latency.
REQ-031 In RUN, 1-cycle sw_rst_req_i -> usr_rst_n=0 and sys_ready_o=0 on that edge; fetch_enable_o=0 next edge; usr_clk phase undisturbed; RUN re-entered after >=32 cycles at a usr_clk falling edge.
REQ-032 sw_rst_req_i asserted while in RELEASE -> state returns to HOLD and usr_rst_n never pulses high.
REQ-033 rst_n pulsed low mid-RUN for less than one clk period -> usr_rst_n, usr_clk and fetch_enable_o low immediately; full sequence of REQ-028 repeats.
